// File: rtl/divider_8_ctrl_if.sv
// divider_8_ctrl_if: operand, button and result bundle for the 8-bit
// divide sequencer. The master drives the dividend/divisor switches and
// the Start/Ack levels; the slave (the sequencer) returns the result and
// its one-hot state indicators.
interface divider_8_ctrl_if;
    logic [7:0] Xin;
    logic [7:0] Yin;
    logic       Start;
    logic       Ack;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Done;
    logic       Qi;
    logic       Qc;
    logic       Qd;
    logic       DivZero;

    modport master (
        output Xin, Yin, Start, Ack,
        input  Quotient, Remainder, Done, Qi, Qc, Qd, DivZero
    );

    modport slave (
        input  Xin, Yin, Start, Ack,
        output Quotient, Remainder, Done, Qi, Qc, Qd, DivZero
    );
endinterface

// File: rtl/divider_8_ctrl.sv
// divider_8_ctrl: one-hot QI/QC/QD sequencer around a restoring
// shift-subtract datapath computing an 8-bit unsigned quotient and
// remainder in 8 compute cycles. The result is held in QD until Ack.
// Optional feature: define DIVIDER_ZERO_CHECK_EN to short-circuit a zero
// divisor straight to QD with Quotient = 8'hFF, Remainder = Xin and the
// DivZero flag raised. Without it DivZero is tied low and a zero divisor
// simply runs the normal 8 steps.
module divider_8_ctrl (
    input  logic              Clk,
    input  logic              Reset,
    divider_8_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        QI = 3'b001,
        QC = 3'b010,
        QD = 3'b100
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [8:0]  r_r;
    logic [7:0]  r_q;
    logic [2:0]  r_count;
    logic [7:0]  r_quotient;
    logic [7:0]  r_remainder;

    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [8:0]  w_r_nxt;
    logic [7:0]  w_q_nxt;
    logic [2:0]  w_count_nxt;
    logic [7:0]  w_quotient_nxt;
    logic [7:0]  w_remainder_nxt;

    logic [8:0]  w_t;
    logic        w_ge;
    logic [8:0]  w_r_step;
    logic [7:0]  w_q_step;

`ifdef DIVIDER_ZERO_CHECK_EN
    logic        r_divzero;
    logic        w_divzero_nxt;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. R[8] is always clear
    // after a step (R < Y); folding it into the compare keeps it live
    // without changing the result.
    always_comb begin
        w_t      = {r_r[7:0], r_x[7]};
        w_ge     = r_r[8] | (w_t >= {1'b0, r_y});
        w_r_step = w_ge ? (w_t - {1'b0, r_y}) : w_t;
        w_q_step = {r_q[6:0], w_ge};
    end

    // State register and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= QI;
            r_x         <= '0;
            r_y         <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            r_divzero   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_r         <= w_r_nxt;
            r_q         <= w_q_nxt;
            r_count     <= w_count_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
`ifdef DIVIDER_ZERO_CHECK_EN
            r_divzero   <= w_divzero_nxt;
`endif
        end
    end

    // Next-state and next-datapath logic; everything holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_r_nxt         = r_r;
        w_q_nxt         = r_q;
        w_count_nxt     = r_count;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
`ifdef DIVIDER_ZERO_CHECK_EN
        w_divzero_nxt   = r_divzero;
`endif
        unique case (r_state)
            QI: begin
                if (bus.Start) begin
`ifdef DIVIDER_ZERO_CHECK_EN
                    if (bus.Yin == 8'h00) begin
                        w_quotient_nxt  = 8'hFF;
                        w_remainder_nxt = bus.Xin;
                        w_divzero_nxt   = 1'b1;
                        w_state_nxt     = QD;
                    end else begin
                        w_x_nxt       = bus.Xin;
                        w_y_nxt       = bus.Yin;
                        w_r_nxt       = '0;
                        w_q_nxt       = '0;
                        w_count_nxt   = '0;
                        w_divzero_nxt = 1'b0;
                        w_state_nxt   = QC;
                    end
`else
                    w_x_nxt     = bus.Xin;
                    w_y_nxt     = bus.Yin;
                    w_r_nxt     = '0;
                    w_q_nxt     = '0;
                    w_count_nxt = '0;
                    w_state_nxt = QC;
`endif
                end
            end
            QC: begin
                w_x_nxt     = {r_x[6:0], 1'b0};
                w_r_nxt     = w_r_step;
                w_q_nxt     = w_q_step;
                w_count_nxt = r_count + 3'd1;
                if (r_count == 3'd7) begin
                    w_quotient_nxt  = w_q_step;
                    w_remainder_nxt = w_r_step[7:0];
                    w_state_nxt     = QD;
                end
            end
            QD: begin
                if (bus.Ack) begin
                    w_state_nxt = QI;
                end
            end
            default: begin
                w_state_nxt = QI;
            end
        endcase
    end

    // Registered results and decoded one-hot indicators.
    always_comb begin
        bus.Quotient  = r_quotient;
        bus.Remainder = r_remainder;
        bus.Qi        = (r_state == QI);
        bus.Qc        = (r_state == QC);
        bus.Qd        = (r_state == QD);
        bus.Done      = (r_state == QD);
`ifdef DIVIDER_ZERO_CHECK_EN
        bus.DivZero   = r_divzero;
`else
        bus.DivZero   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_divider_8_ctrl.sv
// tb_divider_8_ctrl: directed vectors with hand-computed quotient and
// remainder for divider_8_ctrl, covering latency, result hold, Ack/Start
// priority, mid-compute reset and the zero-divisor case in either build.
module tb_divider_8_ctrl;

    logic clk;
    logic rst;

    divider_8_ctrl_if bus ();

    divider_8_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  prev_q;
    logic [7:0]  prev_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one division, count edges until Done, check the held result,
    // then release it with Ack.
    task automatic do_div(input logic [7:0] x, input logic [7:0] y, input logic ack_in,
                          input int unsigned exp_edges, input logic [7:0] exp_q,
                          input logic [7:0] exp_r, input logic exp_dz);
        int unsigned n;
        bus.Xin   = x;
        bus.Yin   = y;
        bus.Ack   = ack_in;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        n = 1;
        while (!bus.Done && n < 20) begin
            if (n == 4) begin
                check("hold_q_mid", bus.Quotient, prev_q);
                check("hold_r_mid", bus.Remainder, prev_r);
                check("qc_mid", bus.Qc, 1'b1);
            end
            tick();
            n++;
        end
        check("latency", n, exp_edges);
        check("quotient", bus.Quotient, exp_q);
        check("remainder", bus.Remainder, exp_r);
        check("qd", bus.Qd, 1'b1);
        check("divzero", bus.DivZero, exp_dz);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        check("qi_after_ack", bus.Qi, 1'b1);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        int unsigned n;
        n_checks  = 0;
        n_pass    = 0;
        prev_q    = 8'h00;
        prev_r    = 8'h00;
        rst       = 1'b1;
        bus.Xin   = 8'h00;
        bus.Yin   = 8'h00;
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        #12;
        check("rst_qi", bus.Qi, 1'b1);
        check("rst_qc", bus.Qc, 1'b0);
        check("rst_qd", bus.Qd, 1'b0);
        check("rst_done", bus.Done, 1'b0);
        check("rst_q", bus.Quotient, 8'h00);
        check("rst_r", bus.Remainder, 8'h00);
        check("rst_dz", bus.DivZero, 1'b0);
        rst = 1'b0;
        tick();

        do_div(8'hC8, 8'h07, 1'b0, 9, 8'h1C, 8'h04, 1'b0);
        do_div(8'hFF, 8'h01, 1'b0, 9, 8'hFF, 8'h00, 1'b0);
        // Ack held high from the start sample: ignored in QI and QC.
        do_div(8'h05, 8'h09, 1'b1, 9, 8'h00, 8'h05, 1'b0);
`ifdef DIVIDER_ZERO_CHECK_EN
        do_div(8'h37, 8'h00, 1'b0, 1, 8'hFF, 8'h37, 1'b1);
`else
        do_div(8'h37, 8'h00, 1'b0, 9, 8'hFF, 8'h37, 1'b0);
`endif
        do_div(8'hC8, 8'h07, 1'b0, 9, 8'h1C, 8'h04, 1'b0);

        // Start held through completion; then Start+Ack together in QD.
        bus.Xin   = 8'hC8;
        bus.Yin   = 8'h07;
        bus.Start = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("hold_qd", bus.Qd, 1'b1);
        bus.Xin = 8'hFF;
        bus.Yin = 8'h10;
        tick();
        check("start_ignored_qd", bus.Qd, 1'b1);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        check("ack_wins", bus.Qi, 1'b1);
        tick();
        check("restart_qc", bus.Qc, 1'b1);
        bus.Start = 1'b0;
        bus.Xin   = 8'h01;
        bus.Yin   = 8'h01;
        n = 1;
        while (!bus.Done && n < 20) begin
            if (n == 5) check("old_q_held", bus.Quotient, 8'h1C);
            tick();
            n++;
        end
        check("restart_latency", n, 9);
        check("restart_q", bus.Quotient, 8'h0F);
        check("restart_r", bus.Remainder, 8'h0F);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;

        // Reset during compute aborts with no partial result.
        bus.Xin   = 8'hC8;
        bus.Yin   = 8'h07;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        check("abort_qi", bus.Qi, 1'b1);
        check("abort_qc", bus.Qc, 1'b0);
        check("abort_q", bus.Quotient, 8'h00);
        check("abort_r", bus.Remainder, 8'h00);
        check("abort_done", bus.Done, 1'b0);
        #2;
        rst = 1'b0;
        prev_q = 8'h00;
        prev_r = 8'h00;
        tick();
        do_div(8'h64, 8'h0A, 1'b0, 9, 8'h0A, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
